// File: rtl/usb_wb_arbiter.sv
// Round-robin two-master Wishbone arbiter in front of the USB core slave port.
// Define WB_ARB_TIMEOUT_EN to enable the STB-without-ACK abort watchdog.
module usb_wb_arbiter #(
    parameter int ADR_W          = 14,
    parameter int DAT_W          = 32,
    parameter int SEL_W          = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             m0_wb_CYC,
    input  logic             m0_wb_STB,
    input  logic             m0_wb_WE,
    input  logic [ADR_W-1:0] m0_wb_ADR,
    input  logic [SEL_W-1:0] m0_wb_SEL,
    input  logic [DAT_W-1:0] m0_wb_DAT_MOSI,
    output logic             m0_wb_ACK,
    output logic             m0_wb_ERR,
    output logic [DAT_W-1:0] m0_wb_DAT_MISO,
    input  logic             m1_wb_CYC,
    input  logic             m1_wb_STB,
    input  logic             m1_wb_WE,
    input  logic [ADR_W-1:0] m1_wb_ADR,
    input  logic [SEL_W-1:0] m1_wb_SEL,
    input  logic [DAT_W-1:0] m1_wb_DAT_MOSI,
    output logic             m1_wb_ACK,
    output logic             m1_wb_ERR,
    output logic [DAT_W-1:0] m1_wb_DAT_MISO,
    output logic             s_wb_CYC,
    output logic             s_wb_STB,
    output logic             s_wb_WE,
    output logic [ADR_W-1:0] s_wb_ADR,
    output logic [SEL_W-1:0] s_wb_SEL,
    output logic [DAT_W-1:0] s_wb_DAT_MOSI,
    input  logic             s_wb_ACK,
    input  logic [DAT_W-1:0] s_wb_DAT_MISO,
    output logic [1:0]       grant
);

`ifdef WB_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN   = 2'd1,
        ABORT = 2'd2,
        DRAIN = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1
    } state_t;
`endif

    state_t     state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic       last_q, last_d;
    logic       own;
    logic       own_cyc;
    logic       in_own;
    logic       pick1;
    logic       tmo_hit;

    assign own     = grant_q[1];
    assign own_cyc = own ? m1_wb_CYC : m0_wb_CYC;
    assign in_own  = (state_q == OWN);
    assign grant   = grant_q;

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tmo_cnt;

    assign tmo_hit = in_own && s_wb_STB && !s_wb_ACK && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (in_own && s_wb_STB && !s_wb_ACK) begin
            tmo_cnt <= tmo_hit ? 16'd0 : tmo_cnt + 16'd1;
        end else begin
            tmo_cnt <= '0;
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
    assign tmo_hit    = 1'b0;
`endif

    // Tie goes to the master not served last; last_q=1 means m1 went last.
    assign pick1 = m1_wb_CYC && (!m0_wb_CYC || !last_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (m0_wb_CYC || m1_wb_CYC) begin
                    state_d = OWN;
                    grant_d = pick1 ? 2'b10 : 2'b01;
                end
            end
            OWN: begin
                if (!own_cyc) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                    last_d  = own;
                end else if (tmo_hit) begin
`ifdef WB_ARB_TIMEOUT_EN
                    state_d = ABORT;
`endif
                end
            end
`ifdef WB_ARB_TIMEOUT_EN
            ABORT: begin
                state_d = DRAIN;
            end
            DRAIN: begin
                if (!own_cyc) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                    last_d  = own;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    always_comb begin
        s_wb_CYC      = 1'b0;
        s_wb_STB      = 1'b0;
        s_wb_WE       = 1'b0;
        s_wb_ADR      = '0;
        s_wb_SEL      = '0;
        s_wb_DAT_MOSI = '0;
        if (in_own) begin
            if (own) begin
                s_wb_CYC      = m1_wb_CYC;
                s_wb_STB      = m1_wb_STB;
                s_wb_WE       = m1_wb_WE;
                s_wb_ADR      = m1_wb_ADR;
                s_wb_SEL      = m1_wb_SEL;
                s_wb_DAT_MOSI = m1_wb_DAT_MOSI;
            end else begin
                s_wb_CYC      = m0_wb_CYC;
                s_wb_STB      = m0_wb_STB;
                s_wb_WE       = m0_wb_WE;
                s_wb_ADR      = m0_wb_ADR;
                s_wb_SEL      = m0_wb_SEL;
                s_wb_DAT_MOSI = m0_wb_DAT_MOSI;
            end
        end
    end

    assign m0_wb_ACK      = in_own && grant_q[0] && s_wb_ACK;
    assign m1_wb_ACK      = in_own && grant_q[1] && s_wb_ACK;
    assign m0_wb_DAT_MISO = grant_q[0] ? s_wb_DAT_MISO : '0;
    assign m1_wb_DAT_MISO = grant_q[1] ? s_wb_DAT_MISO : '0;

`ifdef WB_ARB_TIMEOUT_EN
    assign m0_wb_ERR = (state_q == ABORT) && grant_q[0];
    assign m1_wb_ERR = (state_q == ABORT) && grant_q[1];
`else
    assign m0_wb_ERR = 1'b0;
    assign m1_wb_ERR = 1'b0;
`endif

endmodule

// File: doc/usb_wb_arbiter.md
# usb_wb_arbiter

Two-master Wishbone arbiter placed in front of the USB device core's Wishbone slave port. It shares that single slave between the external host bridge and a second on-chip master, such as a future descriptor or endpoint sequencer. Access is granted round-robin and held for a whole CYC burst. An optional watchdog aborts slave transactions that never acknowledge.

## Interface
Parameters:
- ADR_W, 14, address width
- DAT_W, 32, data width
- SEL_W, 4, byte-select width (DAT_W/8)
- TIMEOUT_CYCLES, 64, STB-without-ACK cycles before abort (2..65535; used only with WB_ARB_TIMEOUT_EN)

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- m{0,1}_wb_CYC  input  1  master bus request / cycle
- m{0,1}_wb_STB  input  1  master strobe
- m{0,1}_wb_WE  input  1  master write enable
- m{0,1}_wb_ADR  input  ADR_W  master address
- m{0,1}_wb_SEL  input  SEL_W  master byte selects
- m{0,1}_wb_DAT_MOSI  input  DAT_W  master write data
- m{0,1}_wb_ACK  output  1  acknowledge, routed to granted master only
- m{0,1}_wb_ERR  output  1  timeout abort, one-cycle pulse
- m{0,1}_wb_DAT_MISO  output  DAT_W  read data; zero when not granted
- s_wb_CYC, s_wb_STB, s_wb_WE  output  1  to slave
- s_wb_ADR  output  ADR_W  to slave
- s_wb_SEL  output  SEL_W  to slave
- s_wb_DAT_MOSI  output  DAT_W  to slave
- s_wb_ACK  input  1  from slave
- s_wb_DAT_MISO  input  DAT_W  from slave
- grant  output  2  one-hot current owner; 2'b00 when idle

## Operation
- States:
  - IDLE: no owner.
  - OWN: grant holds one master.
  - ABORT: ERR cycle, only with the macro.
  - DRAIN: wait for owner to release CYC, only with the macro.
- IDLE → OWN:
  - Any mN_wb_CYC high at a clock edge grants that master at that edge.
  - If both are high, the grant goes to the master not served last.
  - The last_served register resets to 1, so m0 wins the first tie.
- OWN:
  - s_wb_* are driven combinationally from the owner's inputs.
  - Owner ACK = s_wb_ACK and owner MISO = s_wb_DAT_MISO.
  - The non-owner sees ACK=0, ERR=0, MISO=0.
  - The other master's CYC is ignored. There is no preemption.
- OWN → IDLE:
  - Occurs when the owner's CYC is low at the edge, and last_served is updated.
  - s_wb_CYC/STB are gated by state, so they are low in the IDLE cycle.
  - There is always at least one idle cycle between owners.
- Outside OWN, all s_wb_* outputs are 0.
- Reset, asynchronous at any time including mid-transfer:
  - State goes to IDLE, grant=0, last_served=1, timeout counter=0.
  - All outputs read 0.
  - An in-flight slave transaction is dropped without ACK.

## Timing
- Arbitration latency is one cycle: request at edge N, then s_wb_CYC high during cycle N+1.
- ACK/ERR and MISO are combinational from the slave (zero-latency return path). Back-to-back ACKs within one burst pass through unchanged.
- The `grant` output is registered and changes only on clock edges.

## Configuration
- WB_ARB_TIMEOUT_EN defined:
  - A 16-bit counter clears on s_wb_ACK or whenever s_wb_STB is low.
  - It increments on each OWN cycle with STB high and no ACK.
  - At the edge where the counter equals TIMEOUT_CYCLES-1 and ACK is still low, the state moves to ABORT.
- ABORT lasts one cycle:
  - Owner ERR=1.
  - s_wb_CYC=s_wb_STB=0.
  - ACK forced to 0.
- After ABORT the state goes to DRAIN: s_wb_* stay 0 and the grant is held until the owner's CYC is low, then IDLE.
- An ACK arriving in the same cycle as the limit wins: normal completion, no ERR.
- WB_ARB_TIMEOUT_EN undefined: no counter, no ABORT/DRAIN states, ERR tied to 0, TIMEOUT_CYCLES ignored.

## Test plan
- Reset with both CYC high and rst_n released → grant=01 one cycle after release; s_wb_ADR=m0_wb_ADR; m1_wb_ACK stays 0.
- m0 single read to 0x0010, slave ACK with DAT 0xDEADBEEF → m0_wb_DAT_MISO=0xDEADBEEF on the ACK cycle; m1_wb_DAT_MISO=0.
- Both masters continuously request 4-beat bursts → grants alternate 01,00,10,00,01…; no starvation over 8 bursts.
- m1 owns and m0 raises CYC mid-burst → m1 keeps the grant until its CYC drops; m0 is granted exactly 2 edges later.
- (macro on, TIMEOUT_CYCLES=8) Slave never ACKs → m0_wb_ERR pulses once, 8 cycles after STB; s_wb_CYC low thereafter; grant returns to 00 after m0 drops CYC. With ACK on cycle 8 → ACK and no ERR.
- rst_n pulsed low mid-burst → all outputs 0 asynchronously; after release, the next tie is granted to m0.
